syncin_gen: RTL and testbench



---
 rtl/syncin_gen.sv | 151 +++++++++++++++
 tb/tb_syncin_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/syncin_gen.sv
// Generator of the syncin/veto control inputs for the downstream clock state machine.
// Periodic syncin with double-buffered period/high-time config applied only at period boundaries.
module syncin_gen #(
  parameter int unsigned CntW      = 8,
  parameter int unsigned PeriodDef = 3,
  parameter int unsigned HighDef   = 2,
  parameter int unsigned VetoExt   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable_i,
  input  logic            cfg_we_i,
  input  logic [CntW-1:0] cfg_period_i,
  input  logic [CntW-1:0] cfg_high_i,
  input  logic            hold_i,
  output logic            syncin_o,
  output logic            veto_o,
  output logic            boundary_o,
  output logic            cfg_ack_o,
  output logic            running_o
);

  localparam int unsigned ExtW = (VetoExt > 0) ? $clog2(VetoExt + 1) : 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   per_q, per_d;
  logic [CntW-1:0]   hi_q, hi_d;
  logic [CntW-1:0]   pper_q, pper_d;
  logic [CntW-1:0]   phi_q, phi_d;
  logic              pend_q, pend_d;
  logic [ExtW-1:0]   ext_q, ext_d;
  logic              syncin_q, syncin_d;
  logic              veto_q, veto_d;
  logic              boundary_q, boundary_d;
  logic              ack_q, ack_d;
  logic              running_q, running_d;

  logic wrap;
  logic copy;

  assign wrap = (state_q == StRun) && (cnt_q == per_q);
  // Pending config only lands on a period boundary, or any time while idle.
  assign copy = pend_q && ((state_q == StIdle) || wrap);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      per_q      <= CntW'(PeriodDef);
      hi_q       <= CntW'(HighDef);
      pper_q     <= '0;
      phi_q      <= '0;
      pend_q     <= 1'b0;
      ext_q      <= '0;
      syncin_q   <= 1'b0;
      veto_q     <= 1'b0;
      boundary_q <= 1'b0;
      ack_q      <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      per_q      <= per_d;
      hi_q       <= hi_d;
      pper_q     <= pper_d;
      phi_q      <= phi_d;
      pend_q     <= pend_d;
      ext_q      <= ext_d;
      syncin_q   <= syncin_d;
      veto_q     <= veto_d;
      boundary_q <= boundary_d;
      ack_q      <= ack_d;
      running_q  <= running_d;
    end
  end

  // Next state and period counter; a stop request waits for the wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (enable_i) state_d = StRun;
      end
      StRun: begin
        if (wrap) begin
          cnt_d = '0;
          if (!enable_i) state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Config double buffer; a write coincident with a copy becomes the new pending value.
  always_comb begin
    per_d  = per_q;
    hi_d   = hi_q;
    pper_d = pper_q;
    phi_d  = phi_q;
    pend_d = pend_q;
    if (copy) begin
      per_d  = pper_q;
      hi_d   = phi_q;
      pend_d = 1'b0;
    end
    if (cfg_we_i) begin
      pper_d = cfg_period_i;
      phi_d  = cfg_high_i;
      pend_d = 1'b1;
    end
  end

  // Veto stretcher; hold reloads the extension count.
  always_comb begin
    ext_d  = ext_q;
    veto_d = 1'b0;
    if (hold_i) begin
      ext_d  = ExtW'(VetoExt);
      veto_d = 1'b1;
    end else if (ext_q != '0) begin
      ext_d  = ext_q - ExtW'(1);
      veto_d = 1'b1;
    end
  end

  // Output next values, computed from next state so every output is a flop.
  always_comb begin
    running_d  = (state_d == StRun);
    boundary_d = running_d && (cnt_d == '0);
    syncin_d   = running_d && (cnt_d < hi_d);
    ack_d      = copy;
  end

  assign syncin_o   = syncin_q;
  assign veto_o     = veto_q;
  assign boundary_o = boundary_q;
  assign cfg_ack_o  = ack_q;
  assign running_o  = running_q;

endmodule

// File: tb/tb_syncin_gen.sv
// Directed-vector bench for syncin_gen: stimulus pushes expected outputs per cycle,
// a separate monitor pops and compares {running, boundary, syncin, veto, cfg_ack}.
module tb_syncin_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       cfg_we;
  logic [7:0] cfg_period;
  logic [7:0] cfg_high;
  logic       hold;
  logic       syncin, veto, boundary, cfg_ack, running;

  syncin_gen #(
    .CntW     (8),
    .PeriodDef(3),
    .HighDef  (2),
    .VetoExt  (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable_i    (enable),
    .cfg_we_i    (cfg_we),
    .cfg_period_i(cfg_period),
    .cfg_high_i  (cfg_high),
    .hold_i      (hold),
    .syncin_o    (syncin),
    .veto_o      (veto),
    .boundary_o  (boundary),
    .cfg_ack_o   (cfg_ack),
    .running_o   (running)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         t;
    logic [4:0] e;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare when the expected entry's cycle is presented.
  always @(negedge clk) begin
    logic [4:0] got;
    exp_t       x;
    got = {running, boundary, syncin, veto, cfg_ack};
    if (sb.size() > 0) begin
      x = sb[0];
      if (x.t == cyc) begin
        void'(sb.pop_front());
        checks++;
        if (got !== x.e) begin
          failures++;
          $display("FAIL %s: run/bnd/syn/veto/ack got %b want %b (cycle %0d)",
                   x.nm, got, x.e, cyc);
        end
      end else if (x.t < cyc) begin
        void'(sb.pop_front());
        checks++;
        failures++;
        $display("FAIL %s: entry for cycle %0d never compared, got %b want %b",
                 x.nm, x.t, got, x.e);
      end
    end
  end

  // Drive one cycle of inputs; expect outputs in the following cycle.
  task automatic vec(input logic en, input logic we, input logic [7:0] p,
                     input logic [7:0] h, input logic hd, input logic rs,
                     input logic [4:0] e, input string nm);
    exp_t x;
    @(negedge clk);
    enable     = en;
    cfg_we     = we;
    cfg_period = p;
    cfg_high   = h;
    hold       = hd;
    reset      = rs;
    x.t  = cyc + 1;
    x.e  = e;
    x.nm = nm;
    sb.push_back(x);
  endtask

  // Shorthand for plain run/idle cycles with only enable and hold.
  task automatic run(input logic en, input logic hd, input logic [4:0] e, input string nm);
    vec(en, 1'b0, 8'd0, 8'd0, hd, 1'b0, e, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; cfg_we = 1'b0; cfg_period = '0; cfg_high = '0; hold = 1'b0;

    // Reset state
    vec(0, 0, 0, 0, 0, 1, 5'b00000, "reset0");
    vec(0, 0, 0, 0, 0, 1, 5'b00000, "reset1");
    run(0, 0, 5'b00000, "idle");

    // Defaults P=3 H=2
    run(1, 0, 5'b11100, "en_c0");
    run(1, 0, 5'b10100, "def_c1");
    run(1, 0, 5'b10000, "def_c2");
    run(1, 0, 5'b10000, "def_c3");
    run(1, 0, 5'b11100, "def_c0b");
    run(1, 0, 5'b10100, "def_c1b");

    // Mid-period write P=5 H=1: current period finishes at P=3
    vec(1, 1, 8'd5, 8'd1, 0, 0, 5'b10000, "wr51_c2");
    run(1, 0, 5'b10000, "wr51_c3");
    run(1, 0, 5'b11101, "p5_c0_ack");
    run(1, 0, 5'b10000, "p5_c1");
    run(1, 0, 5'b10000, "p5_c2");
    run(1, 0, 5'b10000, "p5_c3");
    run(1, 0, 5'b10000, "p5_c4");
    run(1, 0, 5'b10000, "p5_c5");
    run(1, 0, 5'b11100, "p5_c0b");

    // H=0: syncin never high
    vec(1, 1, 8'd5, 8'd0, 0, 0, 5'b10000, "wr50_c1");
    run(1, 0, 5'b10000, "wr50_c2");
    run(1, 0, 5'b10000, "wr50_c3");
    run(1, 0, 5'b10000, "wr50_c4");
    run(1, 0, 5'b10000, "wr50_c5");
    run(1, 0, 5'b11001, "h0_c0_ack");
    for (int i = 0; i < 5; i++) run(1, 0, 5'b10000, "h0_mid");
    run(1, 0, 5'b11000, "h0_c0b");

    // H=9 P=4: syncin constantly high
    vec(1, 1, 8'd4, 8'd9, 0, 0, 5'b10000, "wr49_c1");
    for (int i = 0; i < 4; i++) run(1, 0, 5'b10000, "wr49_wait");
    run(1, 0, 5'b11101, "h9_c0_ack");
    for (int i = 0; i < 4; i++) run(1, 0, 5'b10100, "h9_mid");
    run(1, 0, 5'b11100, "h9_c0b");

    // P=0 H=1: boundary and syncin every cycle
    vec(1, 1, 8'd0, 8'd1, 0, 0, 5'b10100, "wr01_c1");
    for (int i = 0; i < 3; i++) run(1, 0, 5'b10100, "wr01_wait");
    run(1, 0, 5'b11101, "p0_ack");
    for (int i = 0; i < 3; i++) run(1, 0, 5'b11100, "p0_run");

    // Veto: hold 3 cycles gives 5 cycles of veto
    run(1, 1, 5'b11110, "hold1");
    run(1, 1, 5'b11110, "hold2");
    run(1, 1, 5'b11110, "hold3");
    run(1, 0, 5'b11110, "ext1");
    run(1, 0, 5'b11110, "ext2");
    run(1, 0, 5'b11100, "veto_off");
    // Re-pulse during extension restarts it
    run(1, 1, 5'b11110, "rp_hold");
    run(1, 0, 5'b11110, "rp_ext1");
    run(1, 1, 5'b11110, "rp_rehold");
    run(1, 0, 5'b11110, "rp_ext1b");
    run(1, 0, 5'b11110, "rp_ext2b");
    run(1, 0, 5'b11100, "rp_off");

    // Back to P=3 H=2, then graceful stop requested at cnt=1
    vec(1, 1, 8'd3, 8'd2, 0, 0, 5'b11100, "wr32");
    run(1, 0, 5'b11101, "p3_c0_ack");
    run(1, 0, 5'b10100, "p3_c1");
    run(0, 0, 5'b10000, "stop_c2");
    run(0, 0, 5'b10000, "stop_c3");
    run(0, 0, 5'b00000, "stop_idle");

    // Two back-to-back writes in idle: two acks, last values active
    vec(0, 1, 8'd6, 8'd3, 0, 0, 5'b00000, "idle_wrA");
    vec(0, 1, 8'd2, 8'd1, 0, 0, 5'b00001, "idle_wrB_ackA");
    run(0, 0, 5'b00001, "idle_ackB");
    run(0, 0, 5'b00000, "idle_noack");
    run(1, 0, 5'b11100, "p2_c0");
    run(1, 0, 5'b10000, "p2_c1");
    run(1, 0, 5'b10000, "p2_c2");
    run(1, 0, 5'b11100, "p2_c0b");

    // Reset at cnt=2 with pending config and hold asserted
    vec(1, 1, 8'd7, 8'd7, 0, 0, 5'b10000, "pre_rst_wr");
    run(1, 1, 5'b10010, "pre_rst_hold");
    vec(1, 0, 8'd0, 8'd0, 1, 1, 5'b00000, "rst_mid");
    run(1, 0, 5'b11100, "post_rst_c0");
    run(1, 0, 5'b10100, "post_rst_c1");
    run(1, 0, 5'b10000, "post_rst_c2");
    run(1, 0, 5'b10000, "post_rst_c3");
    run(1, 0, 5'b11100, "post_rst_noack");
    run(0, 0, 5'b10100, "tail");

    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: pending entries got %0d want 0", sb.size());
    end
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
